// File: rtl/pe_dot_acc.sv
// Streaming dot-product PE: a local RAM operand times a streamed operand, accumulated signed.
// Define PE_SAT_EN to saturate the accumulator; otherwise it wraps. In both builds ovf flags the event.
module pe_dot_acc #(
   parameter int DATA_W     = 16,
   parameter int ACC_W      = 40,
   parameter int L_RAM_SIZE = 6
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  we,
   input  logic [L_RAM_SIZE-1:0] addr,
   input  logic [DATA_W-1:0]     din,
   input  logic                  start,
   input  logic [L_RAM_SIZE:0]   len,
   input  logic                  acc_keep,
   input  logic [DATA_W-1:0]     ain,
   input  logic                  ain_valid,
   output logic                  ain_ready,
   output logic                  busy,
   output logic                  dvalid,
   input  logic                  dready,
   output logic [ACC_W-1:0]      dout,
   output logic                  ovf
);

   localparam int DEPTH = 2 ** L_RAM_SIZE;
   localparam int EXT   = ACC_W + 1 - 2 * DATA_W;
   localparam logic [L_RAM_SIZE:0] LEN_MAX = {1'b1, {L_RAM_SIZE{1'b0}}};
   localparam logic [L_RAM_SIZE:0] CNT_ONE = {{L_RAM_SIZE{1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   logic [DATA_W-1:0]   r_ram [DEPTH];
   logic [DATA_W-1:0]   r_bin;
   state_t              r_state;
   logic [L_RAM_SIZE:0] r_cnt;
   logic [L_RAM_SIZE:0] r_len;
   logic                r_drain;
   logic [2*DATA_W-1:0] r_prod;
   logic                r_prod_v;
   logic [ACC_W-1:0]    r_acc;
   logic [ACC_W-1:0]    r_dout;
   logic                r_ain_ready;
   logic                r_busy;
   logic                r_dvalid;
   logic                r_ovf;

   logic [L_RAM_SIZE:0]   w_len_eff;
   logic [L_RAM_SIZE:0]   w_cnt_inc;
   logic [L_RAM_SIZE-1:0] w_rd_addr;
   logic                  w_consume;
   logic                  w_ram_we;
   logic [2*DATA_W-1:0]   w_ain_x;
   logic [2*DATA_W-1:0]   w_bin_x;
   logic [ACC_W:0]        w_sum;
   logic                  w_acc_ovf;
   logic [ACC_W-1:0]      w_acc_next;

   assign w_len_eff = (len > LEN_MAX) ? LEN_MAX : len;
   assign w_cnt_inc = r_cnt + CNT_ONE;
   assign w_consume = r_ain_ready && ain_valid;
   assign w_ram_we  = we && ((r_state == IDLE) || (r_state == DONE));
   assign w_ain_x   = {{DATA_W{ain[DATA_W-1]}}, ain};
   assign w_bin_x   = {{DATA_W{r_bin[DATA_W-1]}}, r_bin};

   // Look one element ahead on a consume so r_bin always matches the next element.
   always_comb begin
      w_rd_addr = r_cnt[L_RAM_SIZE-1:0];
      if (r_state == IDLE) begin
         w_rd_addr = '0;
      end else if (w_consume) begin
         w_rd_addr = w_cnt_inc[L_RAM_SIZE-1:0];
      end
   end

   // One guard bit: overflow when the two top bits of the widened sum disagree.
   assign w_sum     = {r_acc[ACC_W-1], r_acc} + {{EXT{r_prod[2*DATA_W-1]}}, r_prod};
   assign w_acc_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];

   always_comb begin
      w_acc_next = w_sum[ACC_W-1:0];
`ifdef PE_SAT_EN
      if (w_acc_ovf) begin
         w_acc_next = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
`else
      w_acc_next = w_sum[ACC_W-1:0];
`endif
   end

   always_ff @(posedge aclk) begin
      if (w_ram_we) begin
         r_ram[addr] <= din;
      end
      r_bin <= r_ram[w_rd_addr];
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_len       <= '0;
         r_drain     <= 1'b0;
         r_prod      <= '0;
         r_prod_v    <= 1'b0;
         r_acc       <= '0;
         r_dout      <= '0;
         r_ain_ready <= 1'b0;
         r_busy      <= 1'b0;
         r_dvalid    <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         r_prod_v <= 1'b0;
         if (r_prod_v) begin
            r_acc <= w_acc_next;
            if (w_acc_ovf) begin
               r_ovf <= 1'b1;
            end
         end
         case (r_state)
            IDLE: begin
               if (start) begin
                  if (!acc_keep) begin
                     r_acc <= '0;
                     r_ovf <= 1'b0;
                  end
                  r_len  <= w_len_eff;
                  r_cnt  <= '0;
                  r_busy <= 1'b1;
                  if (w_len_eff == '0) begin
                     r_state  <= DONE;
                     r_dvalid <= 1'b1;
                     r_dout   <= acc_keep ? r_acc : '0;
                  end else begin
                     r_state     <= RUN;
                     r_ain_ready <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (w_consume) begin
                  r_prod   <= w_ain_x * w_bin_x;
                  r_prod_v <= 1'b1;
                  r_cnt    <= w_cnt_inc;
                  if (r_cnt == r_len - CNT_ONE) begin
                     r_state     <= DRAIN;
                     r_ain_ready <= 1'b0;
                     r_drain     <= 1'b0;
                  end
               end
            end
            DRAIN: begin
               // The last product lands in r_acc on the first drain edge.
               if (!r_drain) begin
                  r_drain <= 1'b1;
               end else begin
                  r_drain  <= 1'b0;
                  r_state  <= DONE;
                  r_dvalid <= 1'b1;
                  r_dout   <= r_acc;
               end
            end
            DONE: begin
               if (dready) begin
                  r_state  <= IDLE;
                  r_dvalid <= 1'b0;
                  r_busy   <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign ain_ready = r_ain_ready;
   assign busy      = r_busy;
   assign dvalid    = r_dvalid;
   assign dout      = r_dout;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_pe_dot_acc.sv
// Directed bench for pe_dot_acc: a job-level reference model checked every cycle, plus literal expectations.
module tb_pe_dot_acc;

   localparam int DATA_W = 16;
   localparam int ACC_W  = 32;
   localparam int L_RAM  = 6;
   localparam longint MAXV = (longint'(1) <<< (ACC_W - 1)) - 1;
   localparam longint MINV = -(longint'(1) <<< (ACC_W - 1));
   localparam longint MODV = longint'(1) <<< ACC_W;

   logic              aclk = 1'b0;
   logic              aresetn = 1'b1;
   logic              we = 1'b0;
   logic [L_RAM-1:0]  addr = '0;
   logic [DATA_W-1:0] din = '0;
   logic              start = 1'b0;
   logic [L_RAM:0]    len = '0;
   logic              acc_keep = 1'b0;
   logic [DATA_W-1:0] ain = '0;
   logic              ain_valid = 1'b0;
   logic              ain_ready;
   logic              busy;
   logic              dvalid;
   logic              dready = 1'b0;
   logic [ACC_W-1:0]  dout;
   logic              ovf;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_acc_cyc = 0;
   int q_ain[$];

   // Reference model: phase 0 idle, 1 streaming, 2 result pending, 3 result presented.
   int     m_phase = 0;
   int     m_wait  = 0;
   int     m_cnt   = 0;
   int     m_len   = 0;
   longint m_acc   = 0;
   bit     m_ovf   = 1'b0;
   longint m_mem [64];

   pe_dot_acc #(.DATA_W(DATA_W), .ACC_W(ACC_W), .L_RAM_SIZE(L_RAM)) dut (
      .aclk(aclk), .aresetn(aresetn), .we(we), .addr(addr), .din(din),
      .start(start), .len(len), .acc_keep(acc_keep), .ain(ain), .ain_valid(ain_valid),
      .ain_ready(ain_ready), .busy(busy), .dvalid(dvalid), .dready(dready),
      .dout(dout), .ovf(ovf)
   );

   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc++;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) m_mem[i] = 0;
   end

   always @(posedge aclk or negedge aresetn) begin
      longint s;
      int l;
      if (!aresetn) begin
         m_phase = 0; m_acc = 0; m_ovf = 1'b0; m_cnt = 0;
      end else begin
         if (we && (m_phase == 0 || m_phase == 3)) m_mem[addr] = longint'($signed(din));
         case (m_phase)
            0: if (start) begin
               l = (int'(len) > 64) ? 64 : int'(len);
               if (!acc_keep) begin m_acc = 0; m_ovf = 1'b0; end
               m_len = l; m_cnt = 0;
               m_phase = (l == 0) ? 3 : 1;
            end
            1: if (ain_valid) begin
               s = m_acc + longint'($signed(ain)) * m_mem[m_cnt];
               if (s > MAXV || s < MINV) begin
                  m_ovf = 1'b1;
`ifdef PE_SAT_EN
                  s = (s > MAXV) ? MAXV : MINV;
`else
                  s = (s > MAXV) ? s - MODV : s + MODV;
`endif
               end
               m_acc = s;
               m_cnt++;
               if (m_cnt == m_len) begin m_phase = 2; m_wait = 2; end
            end
            2: begin
               m_wait--;
               if (m_wait == 0) m_phase = 3;
            end
            default: if (dready) m_phase = 0;
         endcase
      end
   end

   always @(negedge aclk) begin
      if (!aresetn) begin
         chk("rst_ain_ready", ain_ready, 0);
         chk("rst_busy", busy, 0);
         chk("rst_dvalid", dvalid, 0);
         chk("rst_dout", dout, 0);
         chk("rst_ovf", ovf, 0);
      end else begin
         chk("ain_ready", ain_ready, m_phase == 1);
         chk("busy", busy, m_phase != 0);
         chk("dvalid", dvalid, m_phase == 3);
         if (m_phase == 3) begin
            chk("dout", $signed(dout), m_acc);
            chk("ovf", ovf, m_ovf);
         end
      end
   end

   task automatic write_ram(input int a, input int d);
      we = 1'b1; addr = L_RAM'(a); din = DATA_W'(d);
      @(posedge aclk); #1;
      we = 1'b0;
   endtask

   task automatic start_job(input int l, input bit keep);
      start = 1'b1; len = (L_RAM + 1)'(l); acc_keep = keep;
      @(posedge aclk); #1;
      start = 1'b0;
   endtask

   task automatic stream(input bit toggle);
      int idx = 0;
      int guard = 0;
      bit gap = 1'b0;
      while (idx < q_ain.size() && guard < 400) begin
         if (toggle && gap) begin
            ain_valid = 1'b0; ain = DATA_W'(100);
         end else begin
            ain_valid = 1'b1; ain = DATA_W'(q_ain[idx]);
         end
         @(negedge aclk);
         gap = 1'b0;
         if (ain_valid && ain_ready) begin
            idx++; last_acc_cyc = cyc; gap = 1'b1;
         end
         @(posedge aclk); #1;
         guard++;
      end
      ain_valid = 1'b0;
      if (idx < q_ain.size()) chk("stream_timeout", idx, q_ain.size());
   endtask

   task automatic wait_result(output int lat);
      int n = 0;
      lat = -1;
      while (n < 50) begin
         @(negedge aclk);
         if (dvalid) begin
            lat = cyc - last_acc_cyc;
            break;
         end
         n++;
      end
      if (n == 50) chk("result_timeout", 0, 1);
   endtask

   task automatic take_result();
      dready = 1'b1;
      @(posedge aclk); #1;
      dready = 1'b0;
   endtask

   initial begin
      int lat;
      #2 aresetn = 1'b0;
      @(posedge aclk); @(posedge aclk); #3;
      chk("reset_dout", dout, 0);
      chk("reset_busy", busy, 0);
      aresetn = 1'b1;
      @(posedge aclk); #1;

      // Basic dot product and latency
      for (int i = 0; i < 4; i++) write_ram(i, i + 1);
      start_job(4, 1'b0);
      q_ain = '{5, 6, 7, 8};
      stream(1'b0);
      wait_result(lat);
      chk("t1_dout", $signed(dout), 70);
      chk("t1_ovf", ovf, 0);
      chk("t1_latency", lat, 3);
      take_result();

      // Continue from previous result, result held under back-pressure
      start_job(4, 1'b1);
      stream(1'b0);
      wait_result(lat);
      chk("t2_dout", $signed(dout), 140);
      for (int i = 0; i < 5; i++) begin
         @(negedge aclk);
         chk("t2_hold_dvalid", dvalid, 1);
         chk("t2_hold_dout", $signed(dout), 140);
      end
      @(posedge aclk); #1;
      take_result();

      // Signed operands with a gapped stream
      write_ram(0, -3); write_ram(1, 2);
      start_job(2, 1'b0);
      q_ain = '{-4, -9};
      stream(1'b1);
      wait_result(lat);
      chk("t3_dout", $signed(dout), -6);
      take_result();

      // Accumulator overflow
      for (int i = 0; i < 4; i++) write_ram(i, -32768);
      start_job(4, 1'b0);
      q_ain = '{-32768, -32768, -32768, -32768};
      stream(1'b0);
      wait_result(lat);
`ifdef PE_SAT_EN
      chk("t4_dout", $signed(dout), 2147483647);
`else
      chk("t4_dout", $signed(dout), 0);
`endif
      chk("t4_ovf", ovf, 1);
      take_result();

      // RAM write during RUN and start during DRAIN are ignored
      start_job(2, 1'b0);
      we = 1'b1; addr = '0; din = DATA_W'(7);
      q_ain = '{1, 1};
      stream(1'b0);
      we = 1'b0;
      start = 1'b1; len = 7'd1; acc_keep = 1'b0;
      @(posedge aclk); #1;
      @(posedge aclk); #1;
      start = 1'b0;
      wait_result(lat);
      chk("t5_dout", $signed(dout), -65536);
      take_result();
      @(negedge aclk);
      chk("t5_no_second_job", busy, 0);
      @(posedge aclk); #1;
      start_job(1, 1'b0);
      q_ain = '{1};
      stream(1'b0);
      wait_result(lat);
      chk("t5_ram_kept", $signed(dout), -32768);
      take_result();
      start_job(0, 1'b0);
      @(negedge aclk);
      chk("t5_len0_dvalid", dvalid, 1);
      chk("t5_len0_dout", $signed(dout), 0);
      @(posedge aclk); #1;
      take_result();

      // Length clamped to RAM depth
      for (int i = 0; i < 64; i++) write_ram(i, i - 32);
      start_job(100, 1'b0);
      q_ain.delete();
      for (int i = 0; i < 64; i++) q_ain.push_back(1);
      stream(1'b0);
      wait_result(lat);
      chk("t6_dout", $signed(dout), -32);
      take_result();

      // Reset mid-job, then a fresh job
      start_job(4, 1'b0);
      q_ain = '{1, 1};
      stream(1'b0);
      #2 aresetn = 1'b0;
      #1;
      chk("t7_rst_busy", busy, 0);
      chk("t7_rst_ain_ready", ain_ready, 0);
      chk("t7_rst_dvalid", dvalid, 0);
      chk("t7_rst_dout", dout, 0);
      chk("t7_rst_ovf", ovf, 0);
      @(posedge aclk); @(posedge aclk); #3;
      aresetn = 1'b1;
      @(negedge aclk);
      chk("t7_idle", busy, 0);
      @(posedge aclk); #1;
      start_job(1, 1'b0);
      q_ain = '{3};
      stream(1'b0);
      wait_result(lat);
      chk("t7_dout", $signed(dout), -96);
      take_result();

      repeat (3) @(posedge aclk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule

// File: doc/pe_dot_acc.md
PE_DOT_ACC -- requirements
Module: pe_dot_acc

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning signed operand width.
REQ-002 SHALL have parameter ACC_W, default 40, meaning signed accumulator/result width, constrained to ACC_W >= 2*DATA_W.
REQ-003 SHALL have parameter L_RAM_SIZE, default 6, meaning local RAM address width (depth 2**L_RAM_SIZE).
REQ-004 SHALL have ports, one per line: name, direction, width, meaning.
- aclk  in  1  sole clock, all logic on its rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- we  in  1  local RAM write strobe.
- addr  in  L_RAM_SIZE  local RAM write address.
- din  in  DATA_W  local RAM write data.
- start  in  1  job start pulse.
- len  in  L_RAM_SIZE+1  job element count.
- acc_keep  in  1  sampled with start; 1 = continue from previous result.
- ain  in  DATA_W  streamed operand.
- ain_valid  in  1  ain qualifier.
- ain_ready  out  1  ain accept; an element is consumed when ain_valid && ain_ready.
- busy  out  1  state != IDLE.
- dvalid  out  1  result valid.
- dready  in  1  result accept.
- dout  out  ACC_W  dot-product result.
- ovf  out  1  sticky per-job overflow flag.

Function
REQ-005 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-006 IDLE: start=1 with effective len != 0 SHALL go to RUN, clear the element counter cnt to 0, and present RAM read address 0 in the same cycle.
REQ-007 IDLE: start=1 with len == 0 SHALL go directly to DONE, with dout = the previous result if acc_keep=1, else 0.
REQ-008 len values above 2**L_RAM_SIZE SHALL be treated as 2**L_RAM_SIZE.
REQ-009 Local RAM SHALL be a synchronous block RAM with a registered read output bin.
REQ-010 RAM writes SHALL take effect only in IDLE or DONE; we in RUN/DRAIN SHALL be ignored.
REQ-011 RAM read address SHALL be cnt+1 in a cycle where an element is consumed and cnt otherwise, so bin always holds peram[cnt] while in RUN.
REQ-012 ain_ready SHALL be 1 only in RUN, giving one element per cycle at full throughput.
REQ-013 Consuming element cnt SHALL register product = ain * bin as a signed 2*DATA_W value.
REQ-014 The product SHALL be sign-extended to ACC_W and added into acc one cycle later.
REQ-015 On consuming element len-1, the FSM SHALL go to DRAIN for exactly 2 cycles, then to DONE.
REQ-016 On entry to RUN, acc SHALL be cleared to 0 unless acc_keep=1, in which case it holds the previous result.
REQ-017 DONE: dvalid=1, with dout=acc and ovf held stable until dready=1.
REQ-018 The cycle with dvalid && dready SHALL return to IDLE; start in that same cycle SHALL be ignored.
REQ-019 start in RUN, DRAIN or DONE SHALL be ignored.
REQ-020 Latency: from consuming the last element to dvalid SHALL be 3 cycles.
REQ-021 ovf SHALL be cleared at job start unless acc_keep=1, and set when any accumulate exceeds the signed ACC_W range.

Reset
REQ-022 aresetn=0 SHALL asynchronously force: state IDLE, cnt 0, acc 0, product register 0, dout 0, dvalid 0, ain_ready 0, busy 0, ovf 0.
REQ-023 Reset mid-job SHALL abort the job with no result produced.
REQ-024 RAM contents SHALL NOT be reset.
REQ-025 Deassertion SHALL take effect at the first rising edge of aclk after release.

Configuration
REQ-026 Macro PE_SAT_EN defined: accumulation SHALL saturate to +(2**(ACC_W-1))-1 or -(2**(ACC_W-1)), and ovf SHALL flag saturation.
REQ-027 Macro PE_SAT_EN undefined: accumulation SHALL wrap modulo 2**ACC_W, and ovf SHALL flag wrap.
REQ-028 The port list SHALL be identical in both builds.

Verification
REQ-029 Load peram[0..3] = 1, 2, 3, 4; start len=4 acc_keep=0; stream ain 5, 6, 7, 8 with ain_valid always 1 -> dout=70, ovf=0, dvalid exactly 3 cycles after the 4th accept.
REQ-030 Repeat REQ-029 with acc_keep=1 -> dout=140; then dready held 0 for 5 cycles -> dout and dvalid stable throughout.
REQ-031 peram[0..1] = -3, 2; ain -4, -9 with ain_valid toggling 1/0 -> dout=-6, and cnt advances only on accepted elements.
REQ-032 DATA_W=16, ACC_W=32, len=4, peram and ain all -32768 -> without PE_SAT_EN dout=0 with ovf=1; with PE_SAT_EN dout=2147483647 with ovf=1.
REQ-033 we to addr 0 during RUN plus start during DRAIN -> RAM unchanged and no second job starts; start with len=0 acc_keep=0 -> DONE next cycle, dout=0.
REQ-034 aresetn pulsed low during RUN after 2 elements -> all outputs 0 immediately and IDLE after release; a new len=1 job -> correct result.
